// File: rtl/memory_reg_16bit_pkg.sv
// Shared constants for the 16-bit storage register slice.
package memory_reg_16bit_pkg;
  localparam int          MEMREG_WIDTH   = 16;
  localparam logic [15:0] MEMREG_RST_VAL = 16'h0000;
endpackage

// File: rtl/memory_cell_1bit.sv
// One storage bit: synchronous active-low reset, load enable as a recirculating mux.
module memory_cell_1bit #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  input  logic en,
  output logic q
);

  always_ff @(posedge clk) begin
    if (!rst) q <= RST_BIT;
    else      q <= en ? d : q;
  end

endmodule

// File: rtl/memory_reg_16bit.sv
// Load-enabled register built from WIDTH single-bit cells; reset loads RST_VAL.
module memory_reg_16bit
  import memory_reg_16bit_pkg::*;
#(
  parameter int                WIDTH   = MEMREG_WIDTH,
  parameter logic [WIDTH-1:0]  RST_VAL = WIDTH'(MEMREG_RST_VAL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("memory_reg_16bit: WIDTH must be at least 1");
    end
  endgenerate

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    memory_cell_1bit #(
      .RST_BIT (RST_VAL[i])
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .d   (d[i]),
      .en  (en),
      .q   (q[i])
    );
  end

endmodule

// File: tb/tb_memory_reg_16bit.sv
// Directed and randomized checks of memory_reg_16bit against a one-word reference model.
module tb_memory_reg_16bit;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] d;
  logic [15:0] q;
  logic [15:0] m;
  int          passed;
  int          total;

  memory_reg_16bit dut (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .en  (en),
    .q   (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag);
    total++;
    assert (q === m) passed++;
    else $error("FAIL %s: q=%h expected=%h", tag, q, m);
  endtask

  // Apply inputs just after an edge, take the next edge, update model, compare.
  task automatic step(input logic r, input logic e, input logic [15:0] dd, input string tag);
    rst = r;
    en  = e;
    d   = dd;
    @(posedge clk);
    #1;
    if (!r)     m = 16'h0000;
    else if (e) m = dd;
    check(tag);
  endtask

  // Wiggle d/en and pulse rst low between edges; q must not move.
  task automatic mid_glitch(input string tag);
    #1;
    d   = 16'($urandom);
    en  = ~en;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    d   = 16'($urandom);
    #1;
    check(tag);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst = 1'b0;
    en  = 1'b0;
    d   = 16'd15;
    m   = 16'h0000;
    @(negedge clk);

    step(1'b0, 1'b0, 16'd15,  "reset_first_edge");
    step(1'b0, 1'b0, 16'd15,  "reset_stays");
    step(1'b0, 1'b1, 16'd400, "reset_dominates_en");
    step(1'b1, 1'b0, 16'd15,  "hold_after_release");
    step(1'b1, 1'b1, 16'd15,  "load_15");
    step(1'b1, 1'b1, 16'd50,  "load_50");
    step(1'b1, 1'b1, 16'd400, "load_400");
    step(1'b1, 1'b0, 16'd35,  "hold_d35");
    step(1'b1, 1'b0, 16'd77,  "hold_d77");
    step(1'b1, 1'b0, 16'd35,  "hold_d35_again");
    mid_glitch("hold_midcycle_d");
    step(1'b1, 1'b1, 16'hFFFF, "load_ffff");
    mid_glitch("rst_pulse_between_edges");
    step(1'b1, 1'b0, 16'h0001, "ffff_survives_pulse");
    step(1'b0, 1'b0, 16'h0001, "rst_across_edge");
    step(1'b1, 1'b1, 16'hA5A5, "load_a5a5");
    step(1'b1, 1'b1, 16'h5A5A, "load_5a5a");
    step(1'b0, 1'b1, 16'hBEEF, "reset_again");
    step(1'b1, 1'b1, 16'h1234, "first_release_edge_loads");

    for (int i = 0; i < 60; i++) begin
      logic       r;
      logic       e;
      logic [15:0] dd;
      r  = ($urandom_range(0, 7) != 0);
      e  = $urandom_range(0, 1) == 1;
      dd = 16'($urandom);
      step(r, e, dd, "random_step");
      if ((i % 7) == 3) mid_glitch("random_midcycle");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
